bcd_counter_7seg: RTL
=====================

// Module: bcd_counter_7seg
// PURPOSE
//  Downstream stage of the clock divider: consumes its slow square wave clk_div as an
//  enable, not as a clock. Runs a DIGITS-wide BCD up/down counter with load and wrap.
//  Drives per-digit seven-segment patterns for the board displays.
//  All logic is on the 50 MHz system clock CLK.
// PARAMETERS
//  DIGITS        4   number of BCD digits (1..8); count width = 4*DIGITS
//  COMMON_ANODE  1   1: segments active-low; 0: active-high
// PORTS
//  CLK       in   1          system clock, 50 MHz; single clock domain
//  RST       in   1          synchronous, active-high reset
//  clk_div   in   1          divided square wave from clock divider; sampled as data
//  en        in   1          count enable; counting occurs only on a tick while en=1
//  up        in   1          direction: 1 = increment, 0 = decrement
//  load      in   1          synchronous load of load_val
//  load_val  in   4*DIGITS   BCD value to load; digit i = bits [4i+3:4i]
//  count     out  4*DIGITS   current BCD count, registered
//  tc        out  1          terminal-count pulse, registered, 1 CLK wide
//  tick      out  1          one-CLK pulse per clk_div rising edge (debug/cascade)
//  seg       out  7*DIGITS   digit i segments {g,f,e,d,c,b,a} at [7i+6:7i]
// BEHAVIOUR
//  Edge detect:
//   - 3-stage shift s1<=clk_div, s2<=s1, s3<=s2; tick = s2 & ~s3 (combinational).
//   - clk_div first sampled high at edge N: tick high in cycle after N+1.
//   - count updates at edge N+2. Exactly one tick per clk_div rising edge.
//   - No tick on a falling edge.
//  Priority at each CLK edge: RST > load > (tick & en) > hold.
//  Reset:
//   - count=0, tc=0, s1..s3=0.
//   - seg shows "0" on every digit: 7'b1000000 if COMMON_ANODE, else 7'b0111111.
//   - The divider shares RST, so clk_div=0 at release; no tick is generated on release.
//  Load:
//   - count <= load_val on the edge load=1, regardless of tick or en; tc=0 that cycle.
//   - A load_val digit >9 is loaded as 0; other digits load unchanged.
//   - A tick coincident with load is dropped, not deferred.
//  Up count (tick&en&up):
//   - BCD ripple: digit 0 +1; a digit at 9 goes to 0 and carries into the next.
//   - All digits 9 -> all 0 (wrap); tc=1 for the one cycle in which count shows the
//     wrapped value.
//  Down count (tick&en&~up):
//   - Digit 0 -1; a digit at 0 goes to 9 and borrows.
//   - All 0 -> all 9 (wrap); tc as above.
//  tc is 0 in every cycle without a wrap update; back-to-back wraps are impossible
//   (ticks are at least 2 CLK apart).
//  Hold: en=0 -> count unchanged; ticks are discarded, not accumulated.
//  Direction change takes effect on the next tick; no extra step is taken.
//  Decode:
//   - seg is combinational from registered count; 0 cycles latency from count.
//   - Digits 0-9 use the standard patterns (active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D
//     6=7D 7=07 8=7F 9=6F).
//   - When COMMON_ANODE=1, seg is the bitwise inverse of these patterns.
//   - An unreachable value >9 shows blank (all segments off).
//  Reset mid-count:
//   - count returns to 0 on that edge.
//   - A tick pending in s2/s3 is discarded.
// TESTING
//  T1 reset: RST=1 for 2 CLK with clk_div toggling -> count=0000, tc=0, tick=0;
//     seg=7'h40 per digit (CA).
//  T2 latency: en=1, up=1, clk_div 0->1 at edge N -> tick high in cycle after N+1 only;
//     count 0000->0001 at edge N+2.
//  T3 carry/wrap up: load 0999, up, one tick -> 1000, tc=0; load 9999, one tick ->
//     0000 and tc=1 for exactly 1 CLK.
//  T4 down/borrow: load 1000, up=0, one tick -> 0999; from 0000 one tick -> 9999, tc=1.
//  T5 priority/hold: load=1 with load_val=12F4 coincident with tick -> count=1204, no
//     step. en=0 over 5 ticks -> count unchanged.
//  T6 reset mid-run: RST asserted 1 cycle after tick, while counting at 0457 ->
//     count=0000 next edge, no step after release.

Source files
------------

// File: rtl/bcd_counter_7seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_7seg
//  Description : DIGITS-wide BCD up/down counter with synchronous load and
//                wrap, advanced by rising edges of a slow divided clock that
//                is sampled as data on CLK. Each digit is decoded to a
//                seven-segment pattern for the board displays.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_counter_7seg #(
  parameter int DIGITS       = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clk_div,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  tick,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int c_W = 4 * DIGITS;

  // clk_div synchroniser / edge-detect chain
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_tick;

  logic [c_W-1:0] r_count;
  logic           r_tc;
  logic [c_W-1:0] w_next;
  logic           w_carry;
  logic [c_W-1:0] w_load_clean;

  // Active-high segment pattern {g,f,e,d,c,b,a}; anything above 9 is blank
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] v_pat;
    case (d)
      4'd0:    v_pat = 7'h3F;
      4'd1:    v_pat = 7'h06;
      4'd2:    v_pat = 7'h5B;
      4'd3:    v_pat = 7'h4F;
      4'd4:    v_pat = 7'h66;
      4'd5:    v_pat = 7'h6D;
      4'd6:    v_pat = 7'h7D;
      4'd7:    v_pat = 7'h07;
      4'd8:    v_pat = 7'h7F;
      4'd9:    v_pat = 7'h6F;
      default: v_pat = 7'h00;
    endcase
    return v_pat;
  endfunction

  // s2 holds the newer sample, s3 the older one: a 0->1 step is a rising edge
  assign w_tick = r_s2 & ~r_s3;

  // Shift clk_div through the sampling chain; reset drops any pending edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= clk_div;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Ripple the +1/-1 through the digits; a carry out of the top digit is a wrap
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (up) begin
          if (r_count[4*i +: 4] >= 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (r_count[4*i +: 4] == 4'd0) begin
            w_next[4*i +: 4] = 4'd9;
          end else begin
            w_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  // Per-digit load sanitising and seven-segment decode
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_load_clean[4*gi +: 4] =
        (load_val[4*gi +: 4] > 4'd9) ? 4'd0 : load_val[4*gi +: 4];

    if (COMMON_ANODE) begin : g_ca
      assign seg[7*gi +: 7] = ~f_decode(r_count[4*gi +: 4]);
    end else begin : g_cc
      assign seg[7*gi +: 7] = f_decode(r_count[4*gi +: 4]);
    end
  end

  // Counter: reset beats load, load beats a tick (which is then lost), else hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clean;
      r_tc    <= 1'b0;
    end else if (w_tick && en) begin
      r_count <= w_next;
      r_tc    <= w_carry;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign tick  = w_tick;

endmodule
`default_nettype wire
